seg7_scan_display: RTL and testbench

//  Time-multiplexed driver for the 4-digit 7-segment display on the stopwatch board. Consumes the
//  BCD digits produced by the timing counters (tenths, seconds units/tens, minutes) and the 400 Hz

---
 rtl/seg7_scan_display_pkg.sv | 38 +++
 rtl/seg7_scan_display_if.sv | 31 +++
 rtl/seg7_scan_display_decode.sv | 27 ++
 rtl/seg7_scan_display.sv | 94 +++++++++
 tb/tb_seg7_scan_display.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_display_pkg.sv
// Shared widths, segment patterns and digit-enable constants for the scan display.
package seg7_scan_display_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 4;
  localparam int unsigned DIG_N = 4;
  localparam int unsigned IDX_W = 2;

  // Segment patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [SEG_W-1:0] SEG_0    = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0000001;

  // One-hot digit enables, pos[0] is the rightmost digit
  localparam logic [DIG_N-1:0] DIG_0 = 4'b0001;
  localparam logic [DIG_N-1:0] DIG_1 = 4'b0010;
  localparam logic [DIG_N-1:0] DIG_2 = 4'b0100;
  localparam logic [DIG_N-1:0] DIG_3 = 4'b1000;

  // Map a slot index to its one-hot digit enable
  function automatic logic [DIG_N-1:0] dig_onehot(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    return DIG_0;
      2'd1:    return DIG_1;
      2'd2:    return DIG_2;
      default: return DIG_3;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Digit inputs, scan strobe and display drive lines of the stopwatch display.
interface seg7_scan_display_if;
  import seg7_scan_display_pkg::*;

  logic             scan;
  logic [BCD_W-1:0] d0;
  logic [BCD_W-1:0] d1;
  logic [BCD_W-1:0] d2;
  logic [BCD_W-1:0] d3;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             e;
  logic             f;
  logic             g;
  logic             dp;
  logic [DIG_N-1:0] pos;

  // Counter/prescaler side: supplies digits and scan, observes the display lines
  modport master (
    output scan, d0, d1, d2, d3,
    input  a, b, c, d, e, f, g, dp, pos
  );

  // Display driver side
  modport slave (
    input  scan, d0, d1, d2, d3,
    output a, b, c, d, e, f, g, dp, pos
  );
endinterface

// File: rtl/seg7_scan_display_decode.sv
// BCD to active-high {a..g} decoder; codes above 9 show a dash.
module seg7_decode
  import seg7_scan_display_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [SEG_W-1:0] o_seg
);

  // Pure pattern lookup; polarity and blanking are handled by the caller
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit 7-segment driver with frame-latched digits,
// leading-zero blanking, decimal points and invalid-BCD dash.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter bit               SEG_ACTIVE_LOW = 1'b0,
  parameter bit               POS_ACTIVE_LOW = 1'b0,
  parameter logic [DIG_N-1:0] DP_MASK        = 4'b1010,
  parameter logic [DIG_N-1:0] LZB_MASK       = 4'b1000
) (
  input  logic                 clk,
  input  logic                 reset,
  seg7_scan_display_if.slave   bus
);

  localparam logic [SEG_W-1:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic             DP_INV  = SEG_ACTIVE_LOW;
  localparam logic [DIG_N-1:0] POS_INV = POS_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [IDX_W-1:0]            r_idx;
  logic                        r_active;
  logic [DIG_N-1:0][BCD_W-1:0] r_lat;
  logic [SEG_W-1:0]            r_seg;
  logic                        r_dp;
  logic [DIG_N-1:0]            r_pos;

  logic [BCD_W-1:0]            w_digit;
  logic [SEG_W-1:0]            w_seg_raw;
  logic                        w_blank;
  logic [SEG_W-1:0]            w_seg_nxt;
  logic                        w_dp_nxt;
  logic [DIG_N-1:0]            w_pos_nxt;

  // Slot pointer advances per scan; whole frame is sampled when the pointer wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx    <= 2'd3;
      r_active <= 1'b0;
      r_lat    <= '0;
    end else if (bus.scan) begin
      r_idx    <= r_idx + 2'd1;
      r_active <= 1'b1;
      if (r_idx == 2'd3) begin
        r_lat <= {bus.d3, bus.d2, bus.d1, bus.d0};
      end
    end
  end

  assign w_digit = r_lat[r_idx];

  seg7_decode u_decode (
    .i_bcd (w_digit),
    .o_seg (w_seg_raw)
  );

  // Active-high view of the selected slot, including blanking and dp placement
  always_comb begin
    w_blank   = LZB_MASK[r_idx] && (w_digit == 4'd0);
    w_seg_nxt = '0;
    w_dp_nxt  = 1'b0;
    w_pos_nxt = '0;
    if (r_active) begin
      w_pos_nxt = dig_onehot(r_idx);
      if (!w_blank) begin
        w_seg_nxt = w_seg_raw;
        w_dp_nxt  = DP_MASK[r_idx];
      end
    end
  end

  // Output register: pos and segments change together, OFF level forced on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= SEG_INV;
      r_dp  <= DP_INV;
      r_pos <= POS_INV;
    end else begin
      r_seg <= w_seg_nxt ^ SEG_INV;
      r_dp  <= w_dp_nxt ^ DP_INV;
      r_pos <= w_pos_nxt ^ POS_INV;
    end
  end

  assign bus.a   = r_seg[6];
  assign bus.b   = r_seg[5];
  assign bus.c   = r_seg[4];
  assign bus.d   = r_seg[3];
  assign bus.e   = r_seg[2];
  assign bus.f   = r_seg[1];
  assign bus.g   = r_seg[0];
  assign bus.dp  = r_dp;
  assign bus.pos = r_pos;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a high-polarity and a low-polarity
// instance share stimulus; a frame/slot reference model predicts each display state.
module tb_seg7_scan_display;

  localparam logic [3:0] DPM = 4'b1010;
  localparam logic [3:0] LZB = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan;
  logic [3:0] dv [4];

  always #5 clk = ~clk;

  seg7_scan_display_if if0 ();
  seg7_scan_display_if if1 ();

  assign if0.scan = scan;
  assign if0.d0   = dv[0];
  assign if0.d1   = dv[1];
  assign if0.d2   = dv[2];
  assign if0.d3   = dv[3];
  assign if1.scan = scan;
  assign if1.d0   = dv[0];
  assign if1.d1   = dv[1];
  assign if1.d2   = dv[2];
  assign if1.d3   = dv[3];

  seg7_scan_display dut_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  seg7_scan_display #(
    .SEG_ACTIVE_LOW (1'b1),
    .POS_ACTIVE_LOW (1'b1)
  ) dut_lo (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which digit is shown, what frame is latched, whether display is live
  string seg_str [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                          "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
  int  m_slot;
  bit  m_active;
  int  m_frame [4];
  logic [11:0] sb [$];

  function automatic logic [6:0] letters(input string s);
    logic [6:0] r;
    int k;
    r = '0;
    for (int i = 0; i < s.len(); i++) begin
      k = int'(s[i]) - 97;
      r[6-k] = 1'b1;
    end
    return r;
  endfunction

  // Expected {pos[3:0], a..g, dp} in active-high terms
  function automatic logic [11:0] model_out();
    logic [3:0] p;
    logic [6:0] s;
    logic       dpt;
    int         v;
    if (!m_active) return 12'h000;
    v = m_frame[m_slot];
    p = 4'(1 << m_slot);
    if (LZB[m_slot] && v == 0) begin
      s   = '0;
      dpt = 1'b0;
    end else begin
      s   = (v < 10) ? letters(seg_str[v]) : letters("g");
      dpt = DPM[m_slot];
    end
    return {p, s, dpt};
  endfunction

  task automatic model_reset();
    m_slot   = 3;
    m_active = 1'b0;
    for (int i = 0; i < 4; i++) m_frame[i] = 0;
  endtask

  task automatic model_scan();
    m_slot   = (m_slot + 1) % 4;
    m_active = 1'b1;
    if (m_slot == 0) begin
      for (int i = 0; i < 4; i++) m_frame[i] = int'(dv[i]);
    end
    sb.push_back(model_out());
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%03h exp=%03h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] act0();
    return {if0.pos, if0.a, if0.b, if0.c, if0.d, if0.e, if0.f, if0.g, if0.dp};
  endfunction

  function automatic logic [11:0] act1();
    return {if1.pos, if1.a, if1.b, if1.c, if1.d, if1.e, if1.f, if1.g, if1.dp};
  endfunction

  // Stimulus helpers; inputs change on negedge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_pulse();
    @(negedge clk);
    scan = 1'b1;
    model_scan();
    @(negedge clk);
    scan = 1'b0;
  endtask

  task automatic scan_burst(input int n);
    @(negedge clk);
    scan = 1'b1;
    repeat (n) begin
      model_scan();
      @(negedge clk);
    end
    scan = 1'b0;
  endtask

  task automatic do_reset();
    idle(2);
    #2;
    reset = 1'b1;
    #1;
    check("async_off_hi", act0(), 12'h000);
    check("async_off_lo", act1(), 12'hFFF);
    model_reset();
    sb.delete();
    idle(3);
    reset = 1'b0;
  endtask

  // Monitor: one pop per scan-driven output update, otherwise outputs must hold
  initial begin : monitor
    bit chk;
    bit pend;
    logic [11:0] exp;
    logic [11:0] last;
    pend = 1'b0;
    last = 12'h000;
    repeat (3) @(posedge clk);
    forever begin
      @(posedge clk);
      chk  = pend;
      pend = scan && !reset;
      #1;
      if (reset) begin
        exp  = 12'h000;
        pend = 1'b0;
      end else if (chk) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow got=empty exp=entry t=%0t", $time);
          exp = last;
        end else begin
          exp = sb.pop_front();
        end
      end else begin
        exp = last;
      end
      check(chk ? "scan_hi" : "hold_hi", act0(), exp);
      check(chk ? "scan_lo" : "hold_lo", act1(), ~exp);
      last = exp;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int sel;
    reset = 1'b1;
    scan  = 1'b0;
    for (int i = 0; i < 4; i++) dv[i] = 4'd8;
    model_reset();
    idle(6);
    reset = 1'b0;
    idle(20);

    // Digits 1,2,3,4 over two frames
    dv[3] = 4'd1; dv[2] = 4'd2; dv[1] = 4'd3; dv[0] = 4'd4;
    repeat (8) scan_pulse();

    // Leading-zero blanking on the minutes digit
    dv[3] = 4'd0; dv[2] = 4'd5; dv[1] = 4'd9; dv[0] = 4'd9;
    repeat (8) scan_pulse();

    // Mid-frame input change is deferred to the next wrap
    dv[2] = 4'd3;
    repeat (4) scan_pulse();
    repeat (2) scan_pulse();
    dv[2] = 4'd7;
    repeat (2) scan_pulse();
    repeat (4) scan_pulse();

    // Invalid BCD shows a dash
    dv[1] = 4'hC; dv[0] = 4'hF;
    repeat (8) scan_pulse();

    // Scan held high advances once per cycle
    scan_burst(6);
    idle(3);

    // Reset mid-frame with slot 2 displayed
    while (m_slot != 2) scan_pulse();
    do_reset();
    dv[0] = 4'd6; dv[1] = 4'd1; dv[2] = 4'd4; dv[3] = 4'd2;
    idle(2);
    repeat (5) scan_pulse();

    // Randomized traffic
    repeat (200) begin
      sel = int'($urandom_range(0, 39));
      if (sel < 14) begin
        scan_pulse();
      end else if (sel < 20) begin
        scan_burst(int'($urandom_range(1, 5)));
      end else if (sel < 26) begin
        idle(int'($urandom_range(1, 4)));
      end else if (sel < 39) begin
        dv[$urandom_range(0, 3)] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end else begin
        do_reset();
      end
    end

    idle(6);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
